// File: rtl/i2c_byte_master_pkg.sv
// Shared I2C byte-master definitions: command codes, FSM states, bit timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_defs;

    // Tick pulses per SCL bit period; the phase counter width derives from it.
    localparam int TICKS_PER_BIT = 4;

    // Index of the acknowledge bit within a byte transfer (bits 0..7 data, 8 ack).
    localparam logic [3:0] ACK_BIT = 4'd8;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level, reset to 1 (idle bus level).
// Latency: 2 clk_in cycles.
// Backpressure: none.
module sync_2ff (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async level through two flops before anyone looks at it.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// I2C byte-level master: executes START, STOP, WRITE-byte and READ-byte commands.
// Latency: 4 ticks (START/STOP) or 36 ticks (WRITE/READ) from acceptance to the done pulse.
// Backpressure: cmd_ready high only in IDLE; cmd_valid is ignored while busy, nothing is queued.
module i2c_byte_master
    import i2c_defs::*;
#(
    parameter int TICKS_PER_BIT = i2c_defs::TICKS_PER_BIT
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       mst_nack,
    output logic       cmd_ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       slv_nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int PW = $clog2(TICKS_PER_BIT);
    localparam logic [PW-1:0] PH0 = PW'(0);
    localparam logic [PW-1:0] PH1 = PW'(1);
    localparam logic [PW-1:0] PH2 = PW'(2);
    localparam logic [PW-1:0] PH3 = PW'(TICKS_PER_BIT - 1);

    state_e        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          nack_q, nack_nxt;
    logic          ack_smp, ack_nxt;
    logic          scl_nxt, sda_nxt;
    logic [7:0]    rd_nxt;
    logic          slv_nxt;
    logic          sda_s;

    sync_2ff u_sda_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (sda_i),
        .q      (sda_s)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);

    // State, phase and all pad-enable/result registers; pads only change on tick edges.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            phase    <= PH0;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            nack_q   <= 1'b0;
            ack_smp  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            rd_data  <= 8'h00;
            slv_nack <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            nack_q   <= nack_nxt;
            ack_smp  <= ack_nxt;
            scl_oe   <= scl_nxt;
            sda_oe   <= sda_nxt;
            rd_data  <= rd_nxt;
            slv_nack <= slv_nxt;
        end
    end

    // Next-state and per-phase pad control for every command.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        nack_nxt  = nack_q;
        ack_nxt   = ack_smp;
        scl_nxt   = scl_oe;
        sda_nxt   = sda_oe;
        rd_nxt    = rd_data;
        slv_nxt   = slv_nack;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    phase_nxt = PH0;
                    bit_nxt   = 4'd0;
                    shreg_nxt = wr_data;
                    nack_nxt  = mst_nack;
                    case (cmd_e'(cmd))
                        CMD_START: state_nxt = ST_START;
                        CMD_STOP:  state_nxt = ST_STOP;
                        CMD_WRITE: state_nxt = ST_WRITE;
                        default:   state_nxt = ST_READ;
                    endcase
                end
            end

            ST_START: begin
                if (tick) begin
                    phase_nxt = phase + PH1;
                    case (phase)
                        PH0:     sda_nxt = 1'b0;
                        PH1:     scl_nxt = 1'b0;
                        PH2:     sda_nxt = 1'b1;
                        default: begin
                            scl_nxt   = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    endcase
                end
            end

            ST_STOP: begin
                if (tick) begin
                    phase_nxt = phase + PH1;
                    case (phase)
                        PH0:     sda_nxt = 1'b1;
                        PH1:     scl_nxt = 1'b0;
                        PH2:     sda_nxt = sda_oe;
                        default: begin
                            sda_nxt   = 1'b0;
                            state_nxt = ST_DONE;
                        end
                    endcase
                end
            end

            ST_WRITE, ST_READ: begin
                if (tick) begin
                    phase_nxt = phase + PH1;
                    case (phase)
                        PH0: begin
                            scl_nxt = 1'b1;
                            if (bit_cnt == ACK_BIT)
                                sda_nxt = (state == ST_READ) ? ~nack_q : 1'b0;
                            else
                                sda_nxt = (state == ST_WRITE) ? ~shreg[7] : 1'b0;
                        end
                        PH1: scl_nxt = 1'b0;
                        PH2: begin
                            // Data bits shift in (and expose the next write bit at [7]); ack bit kept apart.
                            if (bit_cnt == ACK_BIT)
                                ack_nxt = sda_s;
                            else
                                shreg_nxt = {shreg[6:0], sda_s};
                        end
                        default: begin
                            scl_nxt = 1'b1;
                            if (bit_cnt == ACK_BIT) begin
                                state_nxt = ST_DONE;
                                if (state == ST_READ)
                                    rd_nxt = shreg;
                                else
                                    slv_nxt = ack_smp;
                            end else begin
                                bit_nxt = bit_cnt + 4'd1;
                            end
                        end
                    endcase
                end
            end

            ST_DONE: state_nxt = ST_IDLE;

            default: state_nxt = ST_IDLE;
        endcase
    end

    // Phases p0..p2 are compared explicitly; PH3 names the terminal phase for readers.
    logic unused_ph3;
    assign unused_ph3 = ^PH3;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master with a bus monitor, slave model and scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_byte_master;
    import i2c_defs::*;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic       mst_nack = 1'b0;
    logic       cmd_ready, done, slv_nack, scl_oe, sda_oe;
    logic [7:0] rd_data;

    // Slave model controls, driven from the stimulus process.
    logic       slave_present = 1'b1;
    logic [7:0] rd_src = 8'h00;

    // Bus monitor state.
    logic       mon_on;
    logic [1:0] cur_cmd;
    int         bit_idx;
    logic [7:0] mon_byte;
    logic       mon_ack, start_seen, lo_hi, glitch, prev_scl, prev_sda;
    int         tcnt;
    logic       slv_pull;

    wire scl_lvl = !scl_oe;
    wire sda_i   = !sda_oe && !slv_pull;

    typedef struct {
        logic [1:0] c;
        logic [7:0] bval;
        logic       nk;
        int         ticks;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    i2c_byte_master #(.TICKS_PER_BIT(4)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .mst_nack  (mst_nack),
        .cmd_ready (cmd_ready),
        .done      (done),
        .rd_data   (rd_data),
        .slv_nack  (slv_nack),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    always #5 clk_in = ~clk_in;

    // Divider stand-in: one tick every 4 clocks.
    initial begin
        int d = 0;
        forever begin
            @(negedge clk_in);
            d = (d + 1) % 4;
            tick = (d == 0);
        end
    end

    // Open-drain slave: ACKs writes when present, returns rd_src on reads.
    always_comb begin
        slv_pull = 1'b0;
        if (mon_on) begin
            if (cur_cmd == CMD_WRITE && slave_present && bit_idx == 8) slv_pull = 1'b1;
            if (cur_cmd == CMD_READ && bit_idx < 8 && !rd_src[7 - bit_idx]) slv_pull = 1'b1;
        end
    end

    // Bus monitor: bits on SCL rise, bit index on SCL fall, START/STOP shapes, data glitches, tick count.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mon_on <= 1'b0; cur_cmd <= 2'b00; bit_idx <= 0; mon_byte <= 8'h00;
            mon_ack <= 1'b0; start_seen <= 1'b0; lo_hi <= 1'b0; glitch <= 1'b0;
            prev_scl <= 1'b1; prev_sda <= 1'b1; tcnt <= 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                mon_on <= 1'b1; cur_cmd <= cmd; bit_idx <= 0; mon_byte <= 8'h00;
                mon_ack <= 1'b0; start_seen <= 1'b0; lo_hi <= 1'b0; glitch <= 1'b0; tcnt <= 0;
            end else begin
                if (tick && !cmd_ready && !done) tcnt <= tcnt + 1;
                if (scl_lvl && !prev_scl) begin
                    if (bit_idx < 8) mon_byte <= {mon_byte[6:0], sda_i};
                    else if (bit_idx == 8) mon_ack <= sda_i;
                end
                if (!scl_lvl && prev_scl) bit_idx <= bit_idx + 1;
                if (scl_lvl && prev_scl && prev_sda && !sda_i) start_seen <= 1'b1;
                if (scl_lvl && !sda_i) lo_hi <= 1'b1;
                if (scl_lvl && prev_scl && (sda_i != prev_sda) &&
                    (cur_cmd == CMD_WRITE || cur_cmd == CMD_READ)) glitch <= 1'b1;
            end
            prev_scl <= scl_lvl;
            prev_sda <= sda_i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Present a command, record its expected outcome, and hold valid until it is accepted.
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk_in,
                         input logic [7:0] exp_b, input logic exp_nk, input int exp_ticks);
        exp_t e;
        int   n = 0;
        @(negedge clk_in);
        cmd = c; wr_data = d; mst_nack = nk_in; cmd_valid = 1'b1;
        e.c = c; e.bval = exp_b; e.nk = exp_nk; e.ticks = exp_ticks;
        sb_q.push_back(e);
        while (!cmd_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    // Wait for done, pop the oldest expectation and compare bus and result observations.
    task automatic wait_done();
        exp_t e;
        int   n = 0;
        while (!done && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk("sb_empty_at_done", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("ticks_to_done", tcnt, e.ticks);
        case (e.c)
            CMD_START: begin
                chk("start_cond", {31'd0, start_seen}, 32'd1);
                chk("start_scl_oe", {31'd0, scl_oe}, 32'd1);
                chk("start_sda_oe", {31'd0, sda_oe}, 32'd1);
            end
            CMD_STOP: begin
                chk("stop_sda_lo_scl_hi", {31'd0, lo_hi}, 32'd1);
                chk("stop_scl_oe", {31'd0, scl_oe}, 32'd0);
                chk("stop_sda_oe", {31'd0, sda_oe}, 32'd0);
            end
            CMD_WRITE: begin
                chk("wr_bus_byte", {24'd0, mon_byte}, {24'd0, e.bval});
                chk("wr_glitch", {31'd0, glitch}, 32'd0);
                chk("wr_slv_nack", {31'd0, slv_nack}, {31'd0, e.nk});
            end
            default: begin
                chk("rd_data", {24'd0, rd_data}, {24'd0, e.bval});
                chk("rd_ack_bit", {31'd0, mon_ack}, {31'd0, e.nk});
                chk("rd_glitch", {31'd0, glitch}, 32'd0);
            end
        endcase
        @(negedge clk_in);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset and first-cycle state.
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_slv_nack", {31'd0, slv_nack}, 32'd0);

        // START, WRITE 0xA5 acked, READ 0x3C with master NACK.
        slave_present = 1'b1;
        issue(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, 4);
        wait_done();
        issue(CMD_WRITE, 8'hA5, 1'b0, 8'hA5, 1'b0, 36);
        wait_done();
        rd_src = 8'h3C;
        issue(CMD_READ, 8'h00, 1'b1, 8'h3C, 1'b1, 36);
        wait_done();

        // READ with ACK and a different pattern.
        rd_src = 8'hC3;
        issue(CMD_READ, 8'h00, 1'b0, 8'hC3, 1'b0, 36);
        wait_done();

        // STOP held on cmd_valid during a WRITE: taken only after the WRITE completes.
        issue(CMD_WRITE, 8'h5A, 1'b0, 8'h5A, 1'b0, 36);
        @(negedge clk_in);
        cmd = CMD_STOP; cmd_valid = 1'b1;
        begin
            exp_t e;
            e.c = CMD_STOP; e.bval = 8'h00; e.nk = 1'b0; e.ticks = 4;
            sb_q.push_back(e);
        end
        repeat (20) @(negedge clk_in);
        chk("busy_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_done();
        @(negedge clk_in);
        cmd_valid = 1'b0;
        wait_done();

        // WRITE with no slave: ack bit reads released.
        issue(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, 4);
        wait_done();
        slave_present = 1'b0;
        issue(CMD_WRITE, 8'hFF, 1'b0, 8'hFF, 1'b1, 36);
        wait_done();
        slave_present = 1'b1;

        // Reset pulsed at bit 4 of a WRITE.
        issue(CMD_WRITE, 8'h96, 1'b0, 8'h96, 1'b0, 36);
        n = 0;
        while (bit_idx != 4 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("reach_bit4", bit_idx, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("midrst_idle", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("midrst_slv_nack", {31'd0, slv_nack}, 32'd0);
        sb_q.delete();
        @(negedge clk_in);
        rst_n = 1'b1;
        issue(CMD_START, 8'h00, 1'b0, 8'h00, 1'b0, 4);
        wait_done();
        issue(CMD_WRITE, 8'h81, 1'b0, 8'h81, 1'b0, 36);
        wait_done();
        issue(CMD_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 4);
        wait_done();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
